instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Instruction fetch stage; produces the 32-bit instruction words consumed by control_unit.
//  Holds the PC and fetches the word at PC over a req/ack memory handshake.
//  Presents the word plus its PC downstream with valid/ready.
//  Accepts PC redirects from branch/jump resolution.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; must be word aligned
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  en           in   1   fetch enable; 0 blocks new fetches only
//  pc_load      in   1   redirect strobe, one cycle
//  pc_target    in   32  redirect address
//  mem_req      out  1   memory read request
//  mem_addr     out  32  memory read address (always PC, word aligned)
//  mem_ack      in   1   read data valid / transaction done
//  mem_rdata    in   32  read data
//  instr_valid  out  1   instruction/pc_out valid
//  instr_ready  in   1   downstream accepts instruction
//  instruction  out  32  fetched word, to control_unit
//  pc_out       out  32  address of instruction
//  misalign     out  1   only with FETCH_MISALIGN_TRAP_EN, else not present
// BEHAVIOUR
//  Reset, async: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0,
//   instruction=32'h0000_0013 (NOP), pc_out=0, flush=0, misalign=0. Outputs drop immediately.
//  FSM IDLE / FETCH / HOLD:
//   IDLE:  mem_req=0. en=1 -> FETCH.
//   FETCH: mem_req=1, mem_addr=pc. Addr held constant until mem_ack.
//          On ack with no flush: instruction<=mem_rdata, pc_out<=pc, instr_valid<=1,
//          pc<=pc+4 (mod 2^32, so FFFF_FFFC wraps to 0), go to HOLD.
//   HOLD:  outputs stable while instr_ready=0; no mem_req.
//          On instr_ready: instr_valid<=0; en ? FETCH : IDLE.
//  Latency: mem_ack in cycle k -> instr_valid=1 in cycle k+1.
//   Best-case throughput is 1 instr / 3 cycles with 1-cycle ack and ready held at 1.
//  Redirects (pc_load has priority over all else; target[1:0] forced to 00):
//   IDLE: pc<=target; stay IDLE unless en.
//   FETCH, no ack: req/addr stay unchanged; pc<=target, flush<=1.
//    On the later ack: data discarded, flush<=0, stay FETCH at the new pc.
//   FETCH, same cycle as ack: data discarded, pc<=target, stay FETCH.
//   HOLD: instruction squashed (instr_valid<=0 next cycle), pc<=target, en ? FETCH : IDLE.
//   Acked data with flush=1 never raises instr_valid.
//  en=0 during FETCH: outstanding transaction completes normally; en gates only new requests.
//  mem_ack outside FETCH is ignored.
//  Back-to-back pc_load: last one wins.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//   - pc_load with target[1:0]!=0 sets misalign=1 (sticky) and forces IDLE.
//   - Any outstanding ack is discarded and no further fetch occurs.
//   - Only rst or an aligned pc_load clears misalign.
//  Not defined:
//   - misalign port is absent.
//   - Low two target bits are silently cleared.
// TESTING
//  1 rst=1 mid-FETCH -> same cycle mem_req=0, instr_valid=0;
//    after release mem_addr=RESET_PC, instruction=0000_0013.
//  2 en=1, 1-cycle ack, rdata 0020_81B3 @0 then 4000_0033 @4 -> mem_addr 0,4,8;
//    instruction/pc_out = 0020_81B3/0, then 4000_0033/4.
//  3 instr_ready=0 for 5 cycles in HOLD -> instruction, pc_out, instr_valid stable; mem_req=0.
//  4 pc_load target=0x40 while fetching 0x8 and ack delayed 3 cycles ->
//    mem_addr stays 0x8 until ack, no instr_valid, next mem_addr=0x40.
//  5 pc_load 0xFFFF_FFFC, fetch ack -> pc_out=FFFF_FFFC, next mem_addr=0x0.
//  6 pc_load 0x42: macro defined -> misalign=1, mem_req stays 0;
//    macro undefined -> mem_addr=0x40.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, reads words over a req/ack port and hands them downstream with valid/ready.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky misalign trap on unaligned redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        flush_q, flush_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] target_al;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flush_d   = flush_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        target_al = align_word(pc_target);
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif

        case (state_q)
            IDLE: begin
                if (pc_load) pc_d = target_al;
                if (en) state_d = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    // A redirect pending or arriving with the ack makes this word stale.
                    if (flush_q || pc_load) begin
                        flush_d = 1'b0;
                        state_d = en ? FETCH : IDLE;
                    end else begin
                        instr_d  = mem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = HOLD;
                    end
                end else if (pc_load) begin
                    flush_d = 1'b1;
                end
                if (pc_load) pc_d = target_al;
            end
            HOLD: begin
                if (pc_load || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = en ? FETCH : IDLE;
                end
                if (pc_load) pc_d = target_al;
            end
            default: state_d = IDLE;
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        if (pc_load) begin
            if (pc_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                valid_d    = 1'b0;
                flush_d    = 1'b0;
            end else begin
                misalign_d = 1'b0;
            end
        end
        // While trapped nothing is fetched; any outstanding ack lands in IDLE and is ignored.
        if (misalign_d) state_d = IDLE;
`endif

        // The bus address freezes only while a transaction is actually outstanding.
        if (state_q == FETCH && state_d == FETCH && !mem_ack) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            flush_q  <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= NOP;
            pc_out_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            flush_q  <= flush_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`endif

    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = addr_q;
    assign instr_valid = valid_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus pushes expected words, a monitor pops them on valid&ready.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] addr_log[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_acc   = 0;
    int          ack_delay = 1;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .pc_out      (pc_out)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0020_81B3;
            32'h0000_0004: return 32'h4000_0033;
            32'h0000_0008: return 32'h0000_0093;
            32'h0000_000C: return 32'h00A0_0113;
            32'h0000_0040: return 32'h0010_0193;
            32'hFFFF_FFFC: return 32'h0000_006F;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input string name);
        int i = 0;
        while (n_acc < n && i < 100) begin
            tick();
            i++;
        end
        chk(name, n_acc, n);
    endtask

    task automatic wait_valid(input string name);
        int i = 0;
        while (instr_valid !== 1'b1 && i < 100) begin
            tick();
            i++;
        end
        chk1(name, instr_valid, 1'b1);
    endtask

    // Memory model: acks after ack_delay wait cycles of a continuous request.
    initial begin
        int wait_cnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst || !mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_lookup(mem_addr);
                addr_log.push_back(mem_addr);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Monitor: every downstream handshake must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, want none", pc_out, instruction);
                end else begin
                    e = sb.pop_front();
                    chk("instruction", instruction, e.instr);
                    chk("pc_out", pc_out, e.pc);
                end
                n_acc++;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        pc_load     = 1'b0;
        pc_target   = 32'h0;
        instr_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk1("reset_mem_req", mem_req, 1'b0);
        chk1("reset_valid", instr_valid, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'h0000_0000);
        chk("reset_instruction", instruction, 32'h0000_0013);
        chk("reset_pc_out", pc_out, 32'h0000_0000);

        // Reset asserted in the middle of a fetch.
        ack_delay = 10;
        en = 1'b1;
        repeat (2) tick();
        chk1("midfetch_req", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("async_req_drop", mem_req, 1'b0);
        chk1("async_valid_drop", instr_valid, 1'b0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mem_addr", mem_addr, 32'h0000_0000);
        chk("rst_instruction", instruction, 32'h0000_0013);

        // Sequential fetch, ready held high; en dropped while word 8 is outstanding.
        addr_log.delete();
        ack_delay   = 1;
        instr_ready = 1'b1;
        sb.push_back('{32'h0020_81B3, 32'h0000_0000});
        sb.push_back('{32'h4000_0033, 32'h0000_0004});
        sb.push_back('{32'h0000_0093, 32'h0000_0008});
        en = 1'b1;
        wait_acc(2, "seq_two_accepted");
        chk("seq_addr_8", mem_addr, 32'h0000_0008);
        chk1("seq_req_8", mem_req, 1'b1);
        en = 1'b0;
        wait_acc(3, "seq_en0_completes");
        chk1("seq_idle_req", mem_req, 1'b0);
        chk("seq_idle_addr", mem_addr, 32'h0000_000C);
        chk("seq_log_n", addr_log.size(), 3);
        chk("seq_log0", addr_log[0], 32'h0000_0000);
        chk("seq_log1", addr_log[1], 32'h0000_0004);
        chk("seq_log2", addr_log[2], 32'h0000_0008);

        // Downstream stall in HOLD.
        instr_ready = 1'b0;
        sb.push_back('{32'h00A0_0113, 32'h0000_000C});
        en = 1'b1;
        wait_valid("stall_valid_rise");
        for (int i = 0; i < 5; i++) begin
            chk1("stall_valid", instr_valid, 1'b1);
            chk1("stall_no_req", mem_req, 1'b0);
            chk("stall_instr", instruction, 32'h00A0_0113);
            chk("stall_pc_out", pc_out, 32'h0000_000C);
            tick();
        end
        en = 1'b0;
        instr_ready = 1'b1;
        wait_acc(4, "stall_released");

        // Redirect while fetching 0x8 with a slow ack.
        pc_target = 32'h0000_0008;
        pc_load   = 1'b1;
        tick();
        pc_load = 1'b0;
        chk("idle_redirect_addr", mem_addr, 32'h0000_0008);
        chk1("idle_redirect_no_req", mem_req, 1'b0);
        addr_log.delete();
        ack_delay = 3;
        sb.push_back('{32'h0010_0193, 32'h0000_0040});
        en = 1'b1;
        tick();
        pc_target = 32'h0000_0040;
        pc_load   = 1'b1;
        tick();
        pc_load = 1'b0;
        for (int i = 0; i < 20 && mem_addr === 32'h0000_0008; i++) begin
            chk1("flush_req_held", mem_req, 1'b1);
            chk1("flush_no_valid", instr_valid, 1'b0);
            tick();
        end
        chk("flush_new_addr", mem_addr, 32'h0000_0040);
        chk1("flush_new_req", mem_req, 1'b1);
        chk("flush_log_n", addr_log.size(), 1);
        chk("flush_log0", addr_log[0], 32'h0000_0008);
        en = 1'b0;
        wait_acc(5, "flush_target_fetched");

        // Wrap at the top of the address space.
        ack_delay = 1;
        sb.push_back('{32'h0000_006F, 32'hFFFF_FFFC});
        pc_target = 32'hFFFF_FFFC;
        pc_load   = 1'b1;
        en        = 1'b1;
        tick();
        pc_load = 1'b0;
        en      = 1'b0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        chk1("wrap_req", mem_req, 1'b1);
        wait_acc(6, "wrap_fetched");
        chk("wrap_next_addr", mem_addr, 32'h0000_0000);
        chk1("wrap_idle_req", mem_req, 1'b0);

        // Redirect squashes an instruction waiting in HOLD.
        instr_ready = 1'b0;
        en = 1'b1;
        wait_valid("squash_valid_rise");
        pc_target = 32'h0000_0008;
        pc_load   = 1'b1;
        en        = 1'b0;
        tick();
        pc_load = 1'b0;
        chk1("squash_valid", instr_valid, 1'b0);
        chk1("squash_req", mem_req, 1'b0);
        chk("squash_addr", mem_addr, 32'h0000_0008);
        instr_ready = 1'b1;
        repeat (3) tick();
        chk("squash_no_accept", n_acc, 6);

        // Unaligned redirect.
        pc_target = 32'h0000_0042;
        pc_load   = 1'b1;
        en        = 1'b1;
        tick();
        pc_load = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk1("misalign_set", misalign, 1'b1);
        chk1("misalign_no_req", mem_req, 1'b0);
        repeat (3) tick();
        chk1("misalign_still_no_req", mem_req, 1'b0);
        chk1("misalign_sticky", misalign, 1'b1);
        pc_target = 32'h0000_0040;
        pc_load   = 1'b1;
        en        = 1'b0;
        tick();
        pc_load = 1'b0;
        chk1("misalign_cleared", misalign, 1'b0);
        chk("misalign_clear_addr", mem_addr, 32'h0000_0040);
`else
        sb.push_back('{32'h0010_0193, 32'h0000_0040});
        chk("unaligned_addr", mem_addr, 32'h0000_0040);
        chk1("unaligned_req", mem_req, 1'b1);
        en = 1'b0;
        wait_acc(7, "unaligned_fetched");
`endif

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
